// File: rtl/layer1_sequencer_if.sv
// Index-queue and result handshake bundle between Layer 1 sequencer and its neighbours.
// The sequencer is the slave; the queue/Layer 2 side is the master.
interface layer1_sequencer_if #(
   parameter int unsigned N_NODES    = 20,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                           idx_valid;
   logic [ADDR_WIDTH-1:0]          idx_data;
   logic                           idx_last;
   logic                           idx_skip;
   logic                           idx_ready;
   logic                           in_done;
   logic                           out_valid;
   logic [N_NODES*OUT_WIDTH-1:0]   out_data;
   logic                           out_ready;

   modport master (
      output idx_valid, idx_data, idx_last, idx_skip, out_ready,
      input  idx_ready, in_done, out_valid, out_data
   );

   modport slave (
      input  idx_valid, idx_data, idx_last, idx_skip, out_ready,
      output idx_ready, in_done, out_valid, out_data
   );
endinterface

// File: rtl/layer1_sequencer.sv
// Layer 1 sequencer: walks the active-pixel queue, accumulates weight rows onto
// bias-initialised saturating accumulators, then hands ReLU outputs to Layer 2.
module layer1_sequencer #(
   parameter int unsigned N_NODES    = 20,
   parameter int unsigned W_WIDTH    = 8,
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   layer1_sequencer_if.slave            seq,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic [N_NODES*W_WIDTH-1:0]   mem_rdata,
   input  logic                         cfg_req,
   input  logic [ADDR_WIDTH-1:0]        cfg_addr,
   output logic                         cfg_grant,
   input  logic                         bias_we,
   input  logic [N_NODES*W_WIDTH-1:0]   bias_in
);

   localparam int unsigned SUM_W = ACC_WIDTH + 1;
   localparam int unsigned ROW_W = N_NODES * W_WIDTH;
   localparam int unsigned OUT_W = N_NODES * OUT_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
   typedef logic signed [ACC_WIDTH-1:0] acc_t;

   function automatic acc_t sext_w(input logic [W_WIDTH-1:0] w);
      return ACC_WIDTH'($signed(w));
   endfunction

   // Signed add with clamp to the accumulator range instead of wrapping.
   function automatic acc_t sat_add(input acc_t a, input logic [W_WIDTH-1:0] w);
      logic signed [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'($signed(w));
      if (s[SUM_W-1] != s[SUM_W-2]) begin
         if (s[SUM_W-1]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
         return {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
      return s[ACC_WIDTH-1:0];
   endfunction

   function automatic logic [OUT_WIDTH-1:0] relu(input acc_t a);
      if (a[ACC_WIDTH-1]) return '0;
      if (|a[ACC_WIDTH-2:OUT_WIDTH]) return '1;
      return a[OUT_WIDTH-1:0];
   endfunction

   state_t           state_q, state_d;
   acc_t             acc_q [N_NODES];
   acc_t             acc_d [N_NODES];
   acc_t             acc_sum [N_NODES];
   acc_t             acc_bias [N_NODES];
   logic [ROW_W-1:0] bias_q, bias_d, bias_eff;
   logic             pend_q, pend_d;
   logic             idx_ready_q, idx_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             in_done_q, in_done_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             accept;

   // Configuration owns the storage port whenever the datapath is not streaming rows.
   assign cfg_grant = cfg_req && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign mem_addr  = cfg_grant            ? cfg_addr     :
                      (state_q == S_RUN)   ? seq.idx_data : '0;

   assign seq.idx_ready = idx_ready_q;
   assign seq.out_valid = out_valid_q;
   assign seq.out_data  = out_data_q;
   assign seq.in_done   = in_done_q;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      bias_d     = bias_q;
      pend_d     = 1'b0;
      out_data_d = out_data_q;
      accept     = (state_q == S_RUN) && seq.idx_valid;
      bias_eff   = bias_we ? bias_in : bias_q;
      for (int n = 0; n < N_NODES; n++) begin
         acc_sum[n]  = sat_add(acc_q[n], mem_rdata[n*W_WIDTH +: W_WIDTH]);
         acc_bias[n] = sext_w(bias_eff[n*W_WIDTH +: W_WIDTH]);
      end

      case (state_q)
         S_IDLE: begin
            bias_d = bias_eff;
            acc_d  = acc_bias;
            if (!cfg_req && seq.idx_valid) state_d = S_RUN;
         end
         S_RUN: begin
            // pend tracks the row whose read data arrives next cycle
            pend_d = accept && !seq.idx_skip;
            if (pend_q) acc_d = acc_sum;
            if (accept && seq.idx_last) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (pend_q) acc_d = acc_sum;
            for (int n = 0; n < N_NODES; n++) begin
               out_data_d[n*OUT_WIDTH +: OUT_WIDTH] = relu(acc_d[n]);
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            bias_d = bias_eff;
            if (seq.out_ready) begin
               acc_d   = acc_bias;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      idx_ready_d = (state_d == S_RUN);
      out_valid_d = (state_d == S_DONE);
      in_done_d   = (state_d == S_FLUSH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         acc_q       <= '{default: '0};
         bias_q      <= '0;
         pend_q      <= 1'b0;
         idx_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         in_done_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         bias_q      <= bias_d;
         pend_q      <= pend_d;
         idx_ready_q <= idx_ready_d;
         out_valid_q <= out_valid_d;
         in_done_q   <= in_done_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_layer1_sequencer.sv
// Directed bench for layer1_sequencer: queue driver, synchronous weight memory model,
// and a linear sequence of image scenarios with hand-computed results.
module tb_layer1_sequencer;
   localparam int unsigned N     = 20;
   localparam int unsigned AW    = 10;
   localparam int unsigned ROW_W = 160;

   logic              clk = 1'b0;
   logic              reset;
   logic [AW-1:0]     mem_addr;
   logic [ROW_W-1:0]  mem_rdata;
   logic              cfg_req;
   logic [AW-1:0]     cfg_addr;
   logic              cfg_grant;
   logic              bias_we;
   logic [ROW_W-1:0]  bias_in;

   always #5 clk = ~clk;

   layer1_sequencer_if #(.N_NODES(N), .OUT_WIDTH(8), .ADDR_WIDTH(AW)) sif ();

   layer1_sequencer #(
      .N_NODES(N), .W_WIDTH(8), .ACC_WIDTH(16), .OUT_WIDTH(8), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset(reset), .seq(sif),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_grant(cfg_grant),
      .bias_we(bias_we), .bias_in(bias_in)
   );

   logic [ROW_W-1:0] rows [0:1023];
   always @(posedge clk) mem_rdata <= rows[mem_addr];

   typedef struct packed {logic [AW-1:0] a; logic last; logic skip;} ent_t;
   ent_t entq[$];
   ent_t drop;
   int   pops = 0;
   logic fire;

   // Queue model: present head entry, dequeue on a handshake seen before the edge.
   initial begin
      sif.idx_valid = 1'b0; sif.idx_data = '0; sif.idx_last = 1'b0; sif.idx_skip = 1'b0;
      fire = 1'b0;
      forever begin
         @(negedge clk); #1;
         if (entq.size() > 0) begin
            sif.idx_valid = 1'b1; sif.idx_data = entq[0].a;
            sif.idx_last = entq[0].last; sif.idx_skip = entq[0].skip;
         end else begin
            sif.idx_valid = 1'b0; sif.idx_data = '0; sif.idx_last = 1'b0; sif.idx_skip = 1'b0;
         end
         #1;
         fire = sif.idx_valid && sif.idx_ready;
         @(posedge clk);
         if (fire && !reset) begin
            drop = entq.pop_front();
            pops++;
         end
      end
   end

   int total = 0, passed = 0, failed = 0;

   task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk); #3;
   endtask

   function automatic logic [ROW_W-1:0] fill(input logic [7:0] w);
      logic [ROW_W-1:0] r;
      for (int n = 0; n < N; n++) r[n*8 +: 8] = w;
      return r;
   endfunction

   task automatic load_bias(input logic [7:0] b);
      bias_in = fill(b); bias_we = 1'b1;
      step();
      bias_we = 1'b0;
   endtask

   task automatic push(input int a, input logic last, input logic skip);
      ent_t e;
      e.a = AW'(a); e.last = last; e.skip = skip;
      entq.push_back(e);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (sif.in_done !== 1'b1 && n < 2000) begin step(); n++; end
      chk({tag, " in_done"}, sif.in_done, 1);
      chk({tag, " valid_low_at_done"}, sif.out_valid, 0);
   endtask

   task automatic wait_result(input string tag, input logic [ROW_W-1:0] exp);
      wait_done(tag);
      step();
      chk({tag, " out_valid"}, sif.out_valid, 1);
      chk({tag, " out_data"}, sif.out_data, exp);
      chk({tag, " in_done_pulse"}, sif.in_done, 0);
      sif.out_ready = 1'b1;
      step();
      chk({tag, " released"}, sif.out_valid, 0);
      sif.out_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ROW_W-1:0] node_row;
      int n, base;
      reset = 1'b1; cfg_req = 1'b0; cfg_addr = '0; bias_we = 1'b0; bias_in = '0;
      sif.out_ready = 1'b0;
      for (int i = 0; i < 1024; i++) rows[i] = '0;
      rows[3] = fill(8'd10); rows[7] = fill(8'hFE);
      rows[9] = fill(8'd127); rows[10] = fill(8'h80);
      for (int k = 1; k <= 5; k++) rows[10+k] = fill(8'(k));
      for (int i = 0; i < N; i++) node_row[i*8 +: 8] = 8'(3*i);
      rows[5] = node_row;

      repeat (3) step();
      chk("rst idx_ready", sif.idx_ready, 0);
      chk("rst out_valid", sif.out_valid, 0);
      chk("rst out_data", sif.out_data, 0);
      chk("rst in_done", sif.in_done, 0);
      chk("rst cfg_grant", cfg_grant, 0);
      chk("rst mem_addr", mem_addr, 0);
      reset = 1'b0;
      step();

      // Two rows onto bias 5: 5 + 10 - 2
      load_bias(8'd5);
      push(3, 0, 0); push(7, 1, 0);
      wait_result("t1", fill(8'd13));

      load_bias(8'd0);
      push(5, 1, 0);
      wait_result("node_order", node_row);

      load_bias(8'hFC);
      push(0, 1, 1);
      wait_result("skip_neg", fill(8'd0));
      load_bias(8'd100);
      push(0, 1, 1);
      wait_result("skip_pos", fill(8'd100));

      load_bias(8'd127);
      for (int i = 0; i < 40; i++) push(9, i == 39, 0);
      wait_result("sat40", fill(8'd255));
      for (int i = 0; i < 300; i++) push(9, i == 299, 0);
      wait_result("sat_pos", fill(8'd255));
      load_bias(8'h80);
      for (int i = 0; i < 300; i++) push(10, i == 299, 0);
      wait_result("sat_neg", fill(8'd0));

      // ReLU upper boundary: 255 passes, 256 clamps
      load_bias(8'd1);
      push(9, 0, 0); push(9, 1, 0);
      wait_result("relu255", fill(8'd255));
      load_bias(8'd2);
      push(9, 0, 0); push(9, 1, 0);
      wait_result("relu256", fill(8'd255));

      // Configuration request during RUN waits for DONE
      load_bias(8'd0);
      push(3, 0, 0); push(3, 0, 0); push(3, 0, 0); push(7, 1, 0);
      n = 0;
      while (sif.idx_ready !== 1'b1 && n < 20) begin step(); n++; end
      chk("cfg run_entered", sif.idx_ready, 1);
      cfg_req = 1'b1; cfg_addr = 10'h155;
      #1;
      chk("cfg grant_in_run", cfg_grant, 0);
      n = 0;
      while (sif.out_valid !== 1'b1 && n < 50) begin
         step();
         if (sif.out_valid !== 1'b1) chk("cfg grant_held", cfg_grant, 0);
         n++;
      end
      chk("cfg done_valid", sif.out_valid, 1);
      chk("cfg grant_done", cfg_grant, 1);
      chk("cfg mem_addr", mem_addr, 10'h155);
      chk("cfg out_data", sif.out_data, fill(8'd28));
      push(3, 1, 0);
      sif.out_ready = 1'b1;
      step();
      sif.out_ready = 1'b0;
      chk("cfg idle_released", sif.out_valid, 0);
      chk("cfg idle_grant", cfg_grant, 1);
      chk("cfg idle_mem_addr", mem_addr, 10'h155);
      step();
      chk("cfg idle_no_run", sif.idx_ready, 0);
      cfg_req = 1'b0;
      step();
      chk("cfg run_after", sif.idx_ready, 1);
      chk("cfg run_mem_addr", mem_addr, 3);
      wait_result("cfg_img2", fill(8'd10));

      // Back-pressure in DONE with next image waiting and a new bias
      load_bias(8'd5);
      push(3, 1, 0);
      wait_done("bp");
      step();
      push(7, 1, 0);
      bias_in = fill(8'd20); bias_we = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         bias_we = 1'b0;
         chk("bp out_data_stable", sif.out_data, fill(8'd15));
         chk("bp out_valid_held", sif.out_valid, 1);
         chk("bp idx_ready_low", sif.idx_ready, 0);
      end
      sif.out_ready = 1'b1;
      step();
      sif.out_ready = 1'b0;
      chk("bp released", sif.out_valid, 0);
      wait_result("bp_img2", fill(8'd18));

      // out_ready tied high: one-cycle out_valid, back in IDLE at t+3
      load_bias(8'd0);
      sif.out_ready = 1'b1;
      push(3, 1, 0);
      wait_done("rdy_hi");
      step();
      chk("rdy_hi out_valid", sif.out_valid, 1);
      chk("rdy_hi out_data", sif.out_data, fill(8'd10));
      step();
      chk("rdy_hi idle_valid", sif.out_valid, 0);
      chk("rdy_hi idle_ready", sif.idx_ready, 0);
      sif.out_ready = 1'b0;

      // Reset after two of five entries; remaining three replay on zero bias
      load_bias(8'd50);
      base = pops;
      for (int k = 11; k <= 15; k++) push(k, k == 15, 0);
      n = 0;
      while ((pops - base) < 2 && n < 50) begin step(); n++; end
      chk("mid_rst two_taken", 32'(pops - base), 2);
      reset = 1'b1;
      #1;
      chk("mid_rst idx_ready", sif.idx_ready, 0);
      chk("mid_rst out_valid", sif.out_valid, 0);
      chk("mid_rst out_data", sif.out_data, 0);
      chk("mid_rst in_done", sif.in_done, 0);
      chk("mid_rst cfg_grant", cfg_grant, 0);
      chk("mid_rst mem_addr", mem_addr, 0);
      step();
      reset = 1'b0;
      wait_result("mid_rst replay", fill(8'd12));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
